// File: rtl/control_unit.sv
// Hardwired multi-cycle control unit: fetch (T0-T2), decode of a latched opcode,
// and per-class execute sequences (T3-T7) with Moore-decoded datapath strobes.
module control_unit (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  output logic        PCout, IncPC, PCin, MARin,
  output logic        read, write, RAMenable, MDRin, MDRout,
  output logic        IRin, Yin, ALUin, ZLOout, ZHIout, HIin, LOin,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin,
  output logic [4:0]  aluControl,
  output logic        run
);

  typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
  typedef enum logic [3:0] {
    C_RTYPE, C_IMM, C_LD, C_LDI, C_ST, C_MULDIV, C_BR, C_JR, C_NOP, C_HALT
  } cls_t;

  localparam logic [4:0] OP_NOP = 5'b11010;

  state_t     state, next;
  cls_t       cls;
  logic [4:0] op;
  logic [4:0] alu_code;
  logic       unused_ir;

  assign unused_ir = ^IR[26:0];
  assign run       = (state != HALT);

  // Only the opcode is kept; later IR changes cannot disturb the instruction in flight.
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= T0;
      op    <= OP_NOP;
    end else begin
      state <= next;
      if (state == T2) op <= IR[31:27];
    end
  end

  always_comb begin
    cls = C_NOP;
    case (op)
      5'd0:  cls = C_LD;
      5'd1:  cls = C_LDI;
      5'd2:  cls = C_ST;
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10: cls = C_RTYPE;
      5'd11, 5'd12, 5'd13: cls = C_IMM;
      5'd15, 5'd16: cls = C_MULDIV;
      5'd18: cls = C_BR;
      5'd20: cls = C_JR;
      5'd27: cls = C_HALT;
      default: cls = C_NOP;
    endcase
  end

  always_comb begin
    alu_code = 5'b00000;
    case (cls)
      C_RTYPE, C_MULDIV:        alu_code = op;
      C_LD, C_LDI, C_ST, C_BR:  alu_code = 5'b00011;
      C_IMM: begin
        if (op == 5'd12)      alu_code = 5'b00101;
        else if (op == 5'd13) alu_code = 5'b00110;
        else                  alu_code = 5'b00011;
      end
      default:                  alu_code = 5'b00000;
    endcase
  end

  always_comb begin
    next = state;
    case (state)
      T0: next = T1;
      T1: next = T2;
      T2: next = T3;
      T3: begin
        if (cls == C_HALT)                     next = HALT;
        else if (cls == C_JR || cls == C_NOP)  next = T0;
        else                                   next = T4;
      end
      T4: next = T5;
      T5: next = (cls == C_RTYPE || cls == C_IMM || cls == C_LDI) ? T0 : T6;
      T6: next = (cls == C_LD || cls == C_ST) ? T7 : T0;
      T7: next = T0;
      HALT: next = HALT;
      default: next = T0;
    endcase
  end

  always_comb begin
    {PCout, IncPC, PCin, MARin} = '0;
    {read, write, RAMenable, MDRin, MDRout} = '0;
    {IRin, Yin, ALUin, ZLOout, ZHIout, HIin, LOin} = '0;
    {Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin} = '0;
    case (state)
      T0: {PCout, MARin, IncPC} = 3'b111;
      T1: {read, RAMenable, MDRin} = 3'b111;
      T2: {MDRout, IRin} = 2'b11;
      T3: case (cls)
        C_RTYPE, C_IMM:     {Grb, Rout, Yin} = 3'b111;
        C_LD, C_LDI, C_ST:  {Grb, BAout, Yin} = 3'b111;
        C_MULDIV:           {Gra, Rout, Yin} = 3'b111;
        C_BR:               {Gra, Rout, CONin} = 3'b111;
        C_JR:               {Gra, Rout, PCin} = 3'b111;
        default: ;
      endcase
      T4: case (cls)
        C_RTYPE:                   {Grc, Rout, ALUin} = 3'b111;
        C_IMM, C_LD, C_LDI, C_ST:  {Cout, ALUin} = 2'b11;
        C_MULDIV:                  {Grb, Rout, ALUin} = 3'b111;
        C_BR:                      {PCout, Yin} = 2'b11;
        default: ;
      endcase
      T5: case (cls)
        C_RTYPE, C_IMM, C_LDI:  {ZLOout, Gra, Rin} = 3'b111;
        C_LD, C_ST:             {ZLOout, MARin} = 2'b11;
        C_MULDIV:               {ZLOout, LOin} = 2'b11;
        C_BR:                   {Cout, ALUin} = 2'b11;
        default: ;
      endcase
      T6: case (cls)
        C_LD:      {read, RAMenable, MDRin} = 3'b111;
        C_ST:      {Gra, Rout, MDRin} = 3'b111;
        C_MULDIV:  {ZHIout, HIin} = 2'b11;
        C_BR: begin
          ZLOout = 1'b1;
          PCin   = CON_FF;
        end
        default: ;
      endcase
      T7: case (cls)
        C_LD:  {MDRout, Gra, Rin} = 3'b111;
        C_ST:  {write, RAMenable} = 2'b11;
        default: ;
      endcase
      default: ;
    endcase
  end

  assign aluControl = ALUin ? alu_code : 5'b00000;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks instruction sequences cycle by cycle and
// compares every strobe, aluControl and run against hand-written expectations.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] IR;
  logic        CON_FF;
  logic PCout, IncPC, PCin, MARin, read, write, RAMenable, MDRin, MDRout;
  logic IRin, Yin, ALUin, ZLOout, ZHIout, HIin, LOin;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin;
  logic [4:0] aluControl;
  logic       run;

  int compared = 0;
  int mismatched = 0;

  control_unit dut (
    .clock(clock), .clear(clear), .IR(IR), .CON_FF(CON_FF),
    .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .MARin(MARin),
    .read(read), .write(write), .RAMenable(RAMenable), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Yin(Yin), .ALUin(ALUin), .ZLOout(ZLOout), .ZHIout(ZHIout),
    .HIin(HIin), .LOin(LOin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Cout(Cout), .CONin(CONin),
    .aluControl(aluControl), .run(run)
  );

  always #5 clock = ~clock;

  localparam logic [23:0] S_PCOUT = 24'h1 << 23, S_INCPC = 24'h1 << 22, S_PCIN = 24'h1 << 21,
    S_MARIN = 24'h1 << 20, S_READ = 24'h1 << 19, S_WRITE = 24'h1 << 18, S_RAMEN = 24'h1 << 17,
    S_MDRIN = 24'h1 << 16, S_MDROUT = 24'h1 << 15, S_IRIN = 24'h1 << 14, S_YIN = 24'h1 << 13,
    S_ALUIN = 24'h1 << 12, S_ZLO = 24'h1 << 11, S_ZHI = 24'h1 << 10, S_HIIN = 24'h1 << 9,
    S_LOIN = 24'h1 << 8, S_GRA = 24'h1 << 7, S_GRB = 24'h1 << 6, S_GRC = 24'h1 << 5,
    S_RIN = 24'h1 << 4, S_ROUT = 24'h1 << 3, S_BAOUT = 24'h1 << 2, S_COUT = 24'h1 << 1,
    S_CONIN = 24'h1;
  localparam logic [23:0] F0 = S_PCOUT | S_MARIN | S_INCPC;
  localparam logic [23:0] F1 = S_READ | S_RAMEN | S_MDRIN;
  localparam logic [23:0] F2 = S_MDROUT | S_IRIN;

  logic [23:0] obs;
  assign obs = {PCout, IncPC, PCin, MARin, read, write, RAMenable, MDRin, MDRout, IRin,
                Yin, ALUin, ZLOout, ZHIout, HIin, LOin, Gra, Grb, Grc, Rin, Rout,
                BAout, Cout, CONin};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [23:0] es, input logic [4:0] ea,
                     input logic er);
    compared++;
    assert ({obs, aluControl, run} === {es, ea, er})
    else begin
      mismatched++;
      $error("FAIL %s: observed strobes=%h alu=%b run=%b, expected strobes=%h alu=%b run=%b",
             tag, obs, aluControl, run, es, ea, er);
    end
  endtask

  // One clock, then check a running-state cycle.
  task automatic ex(input string tag, input logic [23:0] es, input logic [4:0] ea);
    tick();
    chk(tag, es, ea, 1'b1);
  endtask

  // Assumes T0 was just checked; advances through T1 and T2.
  task automatic fetch(input string tag);
    ex({tag, "_T1"}, F1, 5'b0);
    ex({tag, "_T2"}, F2, 5'b0);
  endtask

  function automatic logic [31:0] mk(input logic [4:0] opc);
    return {opc, 27'h15a5a5};
  endfunction

  initial begin
    clear = 1'b1; CON_FF = 1'b0; IR = mk(5'b00011);
    tick();
    chk("reset_T0", F0, 5'b0, 1'b1);
    clear = 1'b0;

    // add; IR is corrupted after the latch point and must not matter
    fetch("add");
    ex("add_T3", S_GRB | S_ROUT | S_YIN, 5'b0);
    IR = mk(5'b11011);
    ex("add_T4", S_GRC | S_ROUT | S_ALUIN, 5'b00011);
    ex("add_T5", S_ZLO | S_GRA | S_RIN, 5'b0);
    ex("add_T0", F0, 5'b0);

    IR = mk(5'b00010);
    fetch("st");
    ex("st_T3", S_GRB | S_BAOUT | S_YIN, 5'b0);
    ex("st_T4", S_COUT | S_ALUIN, 5'b00011);
    ex("st_T5", S_ZLO | S_MARIN, 5'b0);
    ex("st_T6", S_GRA | S_ROUT | S_MDRIN, 5'b0);
    ex("st_T7", S_WRITE | S_RAMEN, 5'b0);
    ex("st_T0", F0, 5'b0);

    IR = mk(5'b10010);
    fetch("br0");
    ex("br0_T3", S_GRA | S_ROUT | S_CONIN, 5'b0);
    ex("br0_T4", S_PCOUT | S_YIN, 5'b0);
    ex("br0_T5", S_COUT | S_ALUIN, 5'b00011);
    ex("br0_T6", S_ZLO, 5'b0);
    ex("br0_T0", F0, 5'b0);

    fetch("br1");
    ex("br1_T3", S_GRA | S_ROUT | S_CONIN, 5'b0);
    ex("br1_T4", S_PCOUT | S_YIN, 5'b0);
    ex("br1_T5", S_COUT | S_ALUIN, 5'b00011);
    CON_FF = 1'b1;
    ex("br1_T6", S_ZLO | S_PCIN, 5'b0);
    ex("br1_T0", F0, 5'b0);
    CON_FF = 1'b0;

    IR = mk(5'b01111);
    fetch("mul");
    ex("mul_T3", S_GRA | S_ROUT | S_YIN, 5'b0);
    ex("mul_T4", S_GRB | S_ROUT | S_ALUIN, 5'b01111);
    ex("mul_T5", S_ZLO | S_LOIN, 5'b0);
    ex("mul_T6", S_ZHI | S_HIIN, 5'b0);
    ex("mul_T0", F0, 5'b0);

    IR = mk(5'b01100);
    fetch("andi");
    ex("andi_T3", S_GRB | S_ROUT | S_YIN, 5'b0);
    ex("andi_T4", S_COUT | S_ALUIN, 5'b00101);
    ex("andi_T5", S_ZLO | S_GRA | S_RIN, 5'b0);
    ex("andi_T0", F0, 5'b0);

    IR = mk(5'b01101);
    fetch("ori");
    ex("ori_T3", S_GRB | S_ROUT | S_YIN, 5'b0);
    ex("ori_T4", S_COUT | S_ALUIN, 5'b00110);
    ex("ori_T5", S_ZLO | S_GRA | S_RIN, 5'b0);
    ex("ori_T0", F0, 5'b0);

    IR = mk(5'b10100);
    fetch("jr");
    ex("jr_T3", S_GRA | S_ROUT | S_PCIN, 5'b0);
    ex("jr_T0", F0, 5'b0);

    IR = mk(5'b11111);
    fetch("undef");
    ex("undef_T3", 24'h0, 5'b0);
    ex("undef_T0", F0, 5'b0);

    IR = mk(5'b00001);
    fetch("ldi");
    ex("ldi_T3", S_GRB | S_BAOUT | S_YIN, 5'b0);
    ex("ldi_T4", S_COUT | S_ALUIN, 5'b00011);
    ex("ldi_T5", S_ZLO | S_GRA | S_RIN, 5'b0);
    ex("ldi_T0", F0, 5'b0);

    // ld aborted by clear in T6
    IR = mk(5'b00000);
    fetch("ld");
    ex("ld_T3", S_GRB | S_BAOUT | S_YIN, 5'b0);
    ex("ld_T4", S_COUT | S_ALUIN, 5'b00011);
    ex("ld_T5", S_ZLO | S_MARIN, 5'b0);
    ex("ld_T6", F1, 5'b0);
    clear = 1'b1;
    ex("ld_clear_T0", F0, 5'b0);
    clear = 1'b0;

    IR = mk(5'b11011);
    fetch("halt");
    ex("halt_T3", 24'h0, 5'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_idle", 24'h0, 5'b0, 1'b0);
    end
    clear = 1'b1;
    tick();
    chk("halt_clear_T0", F0, 5'b0, 1'b1);
    clear = 1'b0;
    IR = mk(5'b11010);
    fetch("nop");
    ex("nop_T3", 24'h0, 5'b0);
    ex("nop_T0", F0, 5'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
